// File: rtl/vadd_float_control_s_axi_if.sv
// AXI4-Lite control-port bundle shared by the register block and its host.
interface vadd_float_control_s_axi_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) ();
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/vadd_float_control_s_axi.sv
// AXI4-Lite control slave for the vadd kernel: start/status handshake,
// interrupt enable/status, and the scalar/pointer argument registers.
module vadd_float_control_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              ap_clk,
  input  logic                              areset,
  vadd_float_control_s_axi_if.slave         s_axi_control,
  output logic                              interrupt,
  output logic                              ap_start,
  input  logic                              ap_done,
  input  logic                              ap_idle,
  input  logic                              ap_ready,
  output logic [31:0]                       scalar00,
  output logic [63:0]                       axi00_ptr0
);

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_GIE    = 6'h04;
  localparam logic [5:0] ADDR_IER    = 6'h08;
  localparam logic [5:0] ADDR_ISR    = 6'h0C;
  localparam logic [5:0] ADDR_SCALAR = 6'h10;
  localparam logic [5:0] ADDR_PTR_LO = 6'h18;
  localparam logic [5:0] ADDR_PTR_HI = 6'h1C;

  typedef enum logic [1:0] {WRIDLE = 2'd0, WRDATA = 2'd1, WRRESP = 2'd2} wstate_e;
  typedef enum logic [0:0] {RDIDLE = 1'b0, RDDATA = 1'b1} rstate_e;

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic                          awready_s, wready_s, bvalid_s, arready_s, rvalid_s;
  logic                          aw_hs_s, w_hs_s, ar_hs_s;
  logic [5:0]                    waddr_q;
  logic [5:0]                    raddr_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                          wr_ctrl_s, wr_gie_s, wr_ier_s, wr_isr_s, rd_ctrl_s;
  logic                          ap_start_q, auto_restart_q, done_q, ready_q;
  logic                          gie_q, interrupt_q;
  logic [1:0]                    ier_q, isr_q;
  logic [31:0]                   scalar_q, ptr_lo_q, ptr_hi_q;
  logic                          unused_addr_s;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

  // Write channel sequencing: address, then data, then response.
  always_comb begin
    wstate_d  = wstate_q;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (wstate_q)
      WRIDLE: begin
        awready_s = 1'b1;
        if (s_axi_control.awvalid) wstate_d = WRDATA;
        else                       wstate_d = WRIDLE;
      end
      WRDATA: begin
        wready_s = 1'b1;
        if (s_axi_control.wvalid) wstate_d = WRRESP;
        else                      wstate_d = WRDATA;
      end
      WRRESP: begin
        bvalid_s = 1'b1;
        if (s_axi_control.bready) wstate_d = WRIDLE;
        else                      wstate_d = WRRESP;
      end
      default: wstate_d = WRIDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (rstate_q)
      RDIDLE: begin
        arready_s = 1'b1;
        if (s_axi_control.arvalid) rstate_d = RDDATA;
        else                       rstate_d = RDIDLE;
      end
      RDDATA: begin
        rvalid_s = 1'b1;
        if (s_axi_control.rready) rstate_d = RDIDLE;
        else                      rstate_d = RDDATA;
      end
      default: rstate_d = RDIDLE;
    endcase
  end

  assign aw_hs_s   = s_axi_control.awvalid & awready_s;
  assign w_hs_s    = s_axi_control.wvalid & wready_s;
  assign ar_hs_s   = s_axi_control.arvalid & arready_s;
  assign raddr_s   = s_axi_control.araddr[5:0];
  assign wr_ctrl_s = w_hs_s && (waddr_q == ADDR_CTRL) && s_axi_control.wstrb[0];
  assign wr_gie_s  = w_hs_s && (waddr_q == ADDR_GIE)  && s_axi_control.wstrb[0];
  assign wr_ier_s  = w_hs_s && (waddr_q == ADDR_IER)  && s_axi_control.wstrb[0];
  assign wr_isr_s  = w_hs_s && (waddr_q == ADDR_ISR)  && s_axi_control.wstrb[0];
  assign rd_ctrl_s = ar_hs_s && (raddr_s == ADDR_CTRL);
  assign unused_addr_s = ^{s_axi_control.awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                           s_axi_control.araddr[C_S_AXI_ADDR_WIDTH-1:6]};

  // Read mux samples live register values, so a same-cycle write is not yet visible.
  always_comb begin
    rdata_d = {C_S_AXI_DATA_WIDTH{1'b0}};
    case (raddr_s)
      ADDR_CTRL:   rdata_d = {24'd0, auto_restart_q, 3'd0, ready_q, ap_idle, done_q, ap_start_q};
      ADDR_GIE:    rdata_d = {31'd0, gie_q};
      ADDR_IER:    rdata_d = {30'd0, ier_q};
      ADDR_ISR:    rdata_d = {30'd0, isr_q};
      ADDR_SCALAR: rdata_d = scalar_q;
      ADDR_PTR_LO: rdata_d = ptr_lo_q;
      ADDR_PTR_HI: rdata_d = ptr_hi_q;
      default:     rdata_d = {C_S_AXI_DATA_WIDTH{1'b0}};
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate_q <= WRIDLE;
      rstate_q <= RDIDLE;
      waddr_q  <= 6'd0;
      rdata_q  <= {C_S_AXI_DATA_WIDTH{1'b0}};
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      if (aw_hs_s) waddr_q <= s_axi_control.awaddr[5:0];
      if (ar_hs_s) rdata_q <= rdata_d;
    end
  end

  // Status latches and ISR: a hardware set event always beats a clear or toggle.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_q     <= 1'b0;
      auto_restart_q <= 1'b0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
      gie_q          <= 1'b0;
      ier_q          <= 2'd0;
      isr_q          <= 2'd0;
      scalar_q       <= 32'd0;
      ptr_lo_q       <= 32'd0;
      ptr_hi_q       <= 32'd0;
      interrupt_q    <= 1'b0;
    end else begin
      if (wr_ctrl_s && s_axi_control.wdata[0]) ap_start_q <= 1'b1;
      else if (ap_ready && !auto_restart_q)    ap_start_q <= 1'b0;
      if (wr_ctrl_s) auto_restart_q <= s_axi_control.wdata[7];
      if (ap_done)        done_q <= 1'b1;
      else if (rd_ctrl_s) done_q <= 1'b0;
      if (ap_ready)       ready_q <= 1'b1;
      else if (rd_ctrl_s) ready_q <= 1'b0;
      if (wr_gie_s) gie_q <= s_axi_control.wdata[0];
      if (wr_ier_s) ier_q <= s_axi_control.wdata[1:0];
      if (ier_q[0] && ap_done) isr_q[0] <= 1'b1;
      else if (wr_isr_s)       isr_q[0] <= isr_q[0] ^ s_axi_control.wdata[0];
      if (ier_q[1] && ap_ready) isr_q[1] <= 1'b1;
      else if (wr_isr_s)        isr_q[1] <= isr_q[1] ^ s_axi_control.wdata[1];
      if (w_hs_s && waddr_q == ADDR_SCALAR)
        scalar_q <= apply_strb(scalar_q, s_axi_control.wdata, s_axi_control.wstrb);
      if (w_hs_s && waddr_q == ADDR_PTR_LO)
        ptr_lo_q <= apply_strb(ptr_lo_q, s_axi_control.wdata, s_axi_control.wstrb);
      if (w_hs_s && waddr_q == ADDR_PTR_HI)
        ptr_hi_q <= apply_strb(ptr_hi_q, s_axi_control.wdata, s_axi_control.wstrb);
      interrupt_q <= gie_q & (isr_q[0] | isr_q[1]);
    end
  end

  assign s_axi_control.awready = awready_s;
  assign s_axi_control.wready  = wready_s;
  assign s_axi_control.bvalid  = bvalid_s;
  assign s_axi_control.bresp   = 2'b00;
  assign s_axi_control.arready = arready_s;
  assign s_axi_control.rvalid  = rvalid_s;
  assign s_axi_control.rdata   = rdata_q;
  assign s_axi_control.rresp   = 2'b00;

  assign interrupt  = interrupt_q;
  assign ap_start   = ap_start_q;
  assign scalar00   = scalar_q;
  assign axi00_ptr0 = {ptr_hi_q, ptr_lo_q};

endmodule
